keyled_event_writer: RTL
========================

KEYLED_EVENT_WRITER -- requirements
Module: keyled_event_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 10240, number of 32-bit words in the data RAM region (1..16384).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a key level.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port key_n  input  4  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-006 SHALL have port avm_address  output  14  word address to data RAM.
REQ-007 SHALL have port avm_byteenable  output  4  byte lanes; constant 4'hF.
REQ-008 SHALL have port avm_chipselect  output  1  RAM select; high only with avm_write.
REQ-009 SHALL have port avm_write  output  1  one-cycle write strobe; RAM has no waitrequest and accepts every strobe.
REQ-010 SHALL have port avm_writedata  output  32  word written.
REQ-011 SHALL have port avm_clken  output  1  RAM clock enable; 1 whenever reset is low.
REQ-012 SHALL have port leds  output  4  bit i toggles on each accepted press of key i.
REQ-013 SHALL have port wr_ptr  output  14  next event word address.
REQ-014 SHALL have port event_count  output  16  events written, saturating at 16'hFFFF.
REQ-015 SHALL have port busy  output  1  high during CLEAR state.
REQ-016 SHALL have port overflow  output  1  sticky; a press was dropped.

Function
REQ-017 SHALL synchronise each key_n bit through 2 flip-flops (reset value 1).
REQ-018 SHALL keep per-key debounced level (reset 1) and counter; counter clears when sync value equals debounced level, else increments; on reaching DEBOUNCE_CYCLES-1 the debounced level takes the sync value and counter clears.
REQ-019 SHALL treat a debounced 1->0 transition as a press event; 0->1 produces no event.
REQ-020 SHALL set pending[i] in the cycle after press event i; if pending[i] is already set, the press SHALL be dropped and overflow set; leds[i] toggles either way.
REQ-021 SHALL keep a free-running 24-bit timestamp counter (reset 0, wraps 24'hFFFFFF->0).
REQ-022 SHALL implement states CLEAR, IDLE, WRITE; reset state CLEAR.
REQ-023 CLEAR: one strobe per cycle, writedata 0, addresses 0..DEPTH-1 ascending; after address DEPTH-1 go IDLE with wr_ptr=0; busy=1 throughout CLEAR.
REQ-024 IDLE: if pending nonzero, select lowest-index set bit k, latch writedata = {1'b1, 3'b000, onehot(k)[3:0], timestamp[23:0]}, go WRITE; strobes low in IDLE.
REQ-025 WRITE: assert chipselect and write for exactly one cycle at address wr_ptr, clear pending[k] (a simultaneous set of the same bit wins), wr_ptr increments wrapping DEPTH-1->0, event_count increments (saturating), return IDLE.
REQ-026 Presses during CLEAR SHALL be held pending and written after CLEAR completes.
REQ-027 Sustained event rate SHALL be one write per 2 cycles; multiple simultaneous presses SHALL be written in ascending key order.

Reset
REQ-028 While reset is high: all outputs 0 except avm_byteenable=4'hF; state CLEAR; pending, counters, leds, overflow, timestamp cleared.
REQ-029 Reset asserted mid-CLEAR or mid-WRITE SHALL abort immediately; CLEAR restarts from address 0 on release.

Verification (DEPTH=16, DEBOUNCE_CYCLES=4)
REQ-030 Release reset, keys idle -> 16 strobes, addresses 0..15, data 0, busy high 16 cycles then low, wr_ptr=0.
REQ-031 After clear, key_n[2] low for 10 cycles -> one write at address 0, writedata[31:24]=8'h84, leds=4'b0100, event_count=1, wr_ptr=1.
REQ-032 Keys 0 and 3 pressed same cycle -> two writes 2 cycles apart, onehot 4'b0001 then 4'b1000, consecutive addresses.
REQ-033 key_n[1] bouncing with pulses shorter than 4 cycles -> no press event, no write, leds unchanged.
REQ-034 17 spaced presses after clear -> 17th write at address 0 (wrap), event_count=17.
REQ-035 Press key 0 twice during CLEAR -> one write after CLEAR, overflow=1, leds[0]=0.

Source files
------------

// File: rtl/keyled_event_writer.sv
// keyled_event_writer: debounces four push-buttons and logs each press as a timestamped word in a RAM.
// Ports: clk/reset (async, active-high); key_n raw active-low buttons;
// avm_* write-only RAM master (no waitrequest); leds toggle per press;
// wr_ptr next event address; event_count saturating; busy while clearing; overflow sticky drop flag.
module keyled_event_writer #(
  parameter int DEPTH           = 10240,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_n,
  output logic [13:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic        avm_clken,
  output logic [3:0]  leds,
  output logic [13:0] wr_ptr,
  output logic [15:0] event_count,
  output logic        busy,
  output logic        overflow
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [13:0] LAST = 14'(DEPTH - 1);
  typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;
  state_t state_q, state_d;
  logic [3:0] sync1_q, sync2_q, deb_q, deb_d, pend_q, pend_d, leds_q, leds_d, sel_q, sel_d;
  logic [3:0] press, done_mask, low;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [23:0] ts_q, ts_d;
  logic [13:0] clr_q, clr_d, ptr_q, ptr_d;
  logic [15:0] evc_q, evc_d;
  logic [31:0] data_q, data_d;
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == deb_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else cnt_d[i] = cnt_q[i] + CW'(1);
    end
    press     = deb_q & ~deb_d;
    done_mask = (state_q == WRITE) ? sel_q : 4'b0000;
    // a press landing on the bit being retired re-arms it rather than being dropped
    pend_d    = (pend_q & ~done_mask) | press;
    ovf_d     = ovf_q | (|(press & pend_q & ~done_mask));
    leds_d    = leds_q ^ press;
    ts_d      = ts_q + 24'd1;
    // isolate lowest set bit so simultaneous presses drain in ascending key order
    low       = pend_q & (~pend_q + 4'd1);
    state_d   = state_q;
    clr_d     = clr_q;
    ptr_d     = ptr_q;
    evc_d     = evc_q;
    sel_d     = sel_q;
    data_d    = data_q;
    if (state_q == CLEAR) begin
      clr_d = (clr_q == LAST) ? 14'd0 : clr_q + 14'd1;
      if (clr_q == LAST) begin
        state_d = IDLE;
        ptr_d   = 14'd0;
      end
    end else if (state_q == IDLE) begin
      if (|pend_q) begin
        sel_d   = low;
        data_d  = {1'b1, 3'b000, low, ts_q};
        state_d = WRITE;
      end
    end else begin
      ptr_d   = (ptr_q == LAST) ? 14'd0 : ptr_q + 14'd1;
      evc_d   = (&evc_q) ? evc_q : evc_q + 16'd1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      deb_q   <= 4'hF;
      cnt_q   <= '0;
      pend_q  <= '0;
      leds_q  <= '0;
      sel_q   <= '0;
      ovf_q   <= 1'b0;
      ts_q    <= '0;
      state_q <= CLEAR;
      clr_q   <= '0;
      ptr_q   <= '0;
      evc_q   <= '0;
      data_q  <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      leds_q  <= leds_d;
      sel_q   <= sel_d;
      ovf_q   <= ovf_d;
      ts_q    <= ts_d;
      state_q <= state_d;
      clr_q   <= clr_d;
      ptr_q   <= ptr_d;
      evc_q   <= evc_d;
      data_q  <= data_d;
    end
  end
  // strobes are gated by reset so outputs read zero while the register sits in CLEAR
  assign avm_write      = ~reset & (state_q == CLEAR || state_q == WRITE);
  assign avm_chipselect = avm_write;
  assign avm_address    = (state_q == CLEAR) ? clr_q : ptr_q;
  assign avm_writedata  = (state_q == WRITE) ? data_q : 32'd0;
  assign avm_byteenable = 4'hF;
  assign avm_clken      = ~reset;
  assign busy           = ~reset & (state_q == CLEAR);
  assign leds           = leds_q;
  assign wr_ptr         = ptr_q;
  assign event_count    = evc_q;
  assign overflow       = ovf_q;
endmodule
